// File: rtl/mdsa_output_collector.sv
// Captures one N*N sorted frame from MDSA_top and replays it on a valid/ready stream.
// Latency: first element valid 1 cycle after final capture; m_ready stalls hold m_data/m_last.
// Optional in-order check of captured data is built when MDSA_ORDER_CHECK_EN is defined.
module mdsa_output_collector #(
    parameter int DATA_W = 8,
    parameter int N      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              output_enable,
    input  logic [DATA_W-1:0] data_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow,
    output logic              sort_err
);

    localparam int NUM_EL = N * N;
    localparam int PTR_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_EL - 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] mem_q [NUM_EL];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0]  rd_next;
    logic              m_valid_q, m_last_q, frame_done_q, overflow_q;
    logic [DATA_W-1:0] m_data_q;
    logic              capture_en, final_wr;

    // wr_ptr is 0 in IDLE, so one address/compare serves both IDLE and CAPTURE
    assign capture_en = output_enable && (state_q != S_DRAIN);
    assign final_wr   = capture_en && (wr_ptr_q == LAST_IDX);
    assign rd_next    = rd_ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst && capture_en) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_CAPTURE: begin
                    if (output_enable) begin
                        if (final_wr) begin
                            // element 0 is preloaded so m_valid can rise right after the last write
                            state_q   <= S_DRAIN;
                            wr_ptr_q  <= '0;
                            rd_ptr_q  <= '0;
                            m_valid_q <= 1'b1;
                            m_data_q  <= (NUM_EL == 1) ? data_in : mem_q[0];
                            m_last_q  <= (NUM_EL == 1);
                        end else begin
                            state_q  <= S_CAPTURE;
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (output_enable) begin
                        overflow_q <= 1'b1;
                    end
                    if (m_ready) begin
                        if (m_last_q) begin
                            state_q      <= S_IDLE;
                            rd_ptr_q     <= '0;
                            m_valid_q    <= 1'b0;
                            m_last_q     <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            rd_ptr_q <= rd_next;
                            m_data_q <= mem_q[rd_next];
                            m_last_q <= (rd_next == LAST_IDX);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MDSA_ORDER_CHECK_EN
    logic [DATA_W-1:0] prev_q;
    logic              sort_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            sort_err_q <= 1'b0;
        end else if (capture_en) begin
            prev_q <= data_in;
            if (state_q == S_CAPTURE && data_in < prev_q) begin
                sort_err_q <= 1'b1;
            end
        end
    end

    assign sort_err = sort_err_q;
`else
    assign sort_err = 1'b0;
`endif

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdsa_output_collector.sv
// Randomised and directed bench for mdsa_output_collector against a queue-based frame model.
module tb_mdsa_output_collector;

    localparam int DATA_W = 8;
    localparam int NUM_EL = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              output_enable = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              m_valid, m_ready, m_last, frame_done, busy, overflow, sort_err;
    logic [DATA_W-1:0] m_data;

    mdsa_output_collector #(.DATA_W(DATA_W), .N(4)) dut (
        .clk(clk), .rst(rst), .output_enable(output_enable), .data_in(data_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .frame_done(frame_done), .busy(busy), .overflow(overflow), .sort_err(sort_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: a frame being gathered and a frame being delivered
    logic [DATA_W-1:0] cap_q[$];
    logic [DATA_W-1:0] drain_q[$];
    bit mdl_on = 0;
    bit exp_done = 0, exp_ovf = 0, exp_serr = 0;

    always @(negedge clk) begin
        bit ev;
        if (mdl_on) begin
            ev = (drain_q.size() > 0);
            check("m_valid", m_valid, ev);
            check("busy", busy, ev || cap_q.size() > 0);
            check("m_last", m_last, ev && drain_q.size() == 1);
            check("frame_done", frame_done, exp_done);
            check("overflow", overflow, exp_ovf);
            check("sort_err", sort_err, exp_serr);
            if (ev) check("m_data", m_data, drain_q[0]);
        end
        if (rst) begin
            cap_q = {};
            drain_q = {};
            exp_done = 0;
            exp_ovf = 0;
            exp_serr = 0;
            mdl_on = 1;
        end else if (mdl_on) begin
            exp_done = 0;
            if (drain_q.size() > 0) begin
                if (output_enable) exp_ovf = 1;
                if (m_ready) begin
                    void'(drain_q.pop_front());
                    if (drain_q.size() == 0) exp_done = 1;
                end
            end else if (output_enable) begin
`ifdef MDSA_ORDER_CHECK_EN
                if (cap_q.size() > 0 && data_in < cap_q[$]) exp_serr = 1;
`endif
                cap_q.push_back(data_in);
                if (cap_q.size() == NUM_EL) begin
                    drain_q = cap_q;
                    cap_q = {};
                end
            end
        end
    end

    // 0: always ready, 1: pattern 1,0,0, 2: random, 3: never ready
    int rdy_mode = 0;
    int cyc = 0;
    logic [DATA_W-1:0] frame_v [NUM_EL];

    task automatic tick(input logic oe, input logic [DATA_W-1:0] d);
        output_enable = oe;
        data_in = d;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: m_ready = (cyc % 3 == 0);
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int m);
        rdy_mode = m;
        cyc = 0;
    endtask

    task automatic send_frame(input int gap_at, input int gap_len);
        for (int i = 0; i < NUM_EL; i++) begin
            if (i == gap_at)
                for (int g = 0; g < gap_len; g++) tick(1'b0, 8'h00);
            tick(1'b1, frame_v[i]);
        end
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 300 && (drain_q.size() > 0 || cap_q.size() > 0); i++) tick(1'b0, 8'h00);
        check("drain_timeout", 32'(drain_q.size() + cap_q.size()), 32'd0);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
    endtask

    task automatic ramp();
        for (int i = 0; i < NUM_EL; i++) frame_v[i] = 8'(i);
    endtask

    initial begin
        m_ready = 1'b0;
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        rst = 1'b0;
        check("rst_m_data", m_data, 32'd0);
        check("rst_m_valid", m_valid, 32'd0);

        // ramp, always ready
        ramp();
        set_mode(0);
        send_frame(-1, 0);
        wait_drain();

        // ramp, ready 1,0,0 pattern
        set_mode(1);
        send_frame(-1, 0);
        wait_drain();

        // ramp with a 5-cycle capture gap
        set_mode(0);
        send_frame(8, 5);
        wait_drain();

        // overflow while draining with sink stalled
        set_mode(3);
        send_frame(-1, 0);
        tick(1'b1, 8'hAA);
        tick(1'b1, 8'hAA);
        tick(1'b0, 8'h00);
        set_mode(0);
        wait_drain();
        send_frame(-1, 0);
        wait_drain();

        // reset mid-capture, then a clean frame
        for (int i = 0; i < 7; i++) tick(1'b1, 8'(8'hF0 + i));
        rst = 1'b1;
        tick(1'b0, 8'h00);
        rst = 1'b0;
        check("rst_mid_m_data", m_data, 32'd0);
        check("rst_mid_busy", busy, 32'd0);
        check("rst_mid_overflow", overflow, 32'd0);
        for (int i = 0; i < NUM_EL; i++) frame_v[i] = 8'(8'h40 + 3 * i);
        set_mode(2);
        send_frame(-1, 0);
        wait_drain();

        // out-of-order frame 0,1,2,9,3,...
        for (int i = 0; i < NUM_EL; i++) frame_v[i] = 8'(i < 3 ? i : (i == 3 ? 9 : (i <= 9 ? i - 1 : i)));
        set_mode(0);
        send_frame(-1, 0);
        wait_drain();

        // random traffic, including oe during drain
        rst = 1'b1;
        tick(1'b0, 8'h00);
        rst = 1'b0;
        set_mode(2);
        for (int i = 0; i < 1500; i++)
            tick(1'($urandom_range(0, 3) != 0), 8'($urandom));
        for (int i = 0; i < 60; i++) tick(1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
